// File: rtl/rns11_pkg.sv
// Shared constants, FSM state type and thermometer-code encoder for the
// mod-11 forward converter.
package rns11_pkg;

  localparam int MOD  = 11;
  localparam int TC_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit i (0-based) is set iff residue >= i+1, so 0 -> all zeros, 10 -> all ones.
  function automatic logic [TC_W-1:0] tc_encode(input logic [3:0] r);
    logic [TC_W-1:0] tc;
    for (int i = 0; i < TC_W; i++) begin
      tc[i] = (int'(r) > i);
    end
    return tc;
  endfunction

endpackage

// File: rtl/rns11_serial_residue.sv
// One operand's MSB-first shift register and running mod-11 residue.
// The shared FSM decides when to load and when to shift.
module rns11_serial_residue
  import rns11_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [3:0]       r_next_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [3:0]       r_q, r_d;
  logic [4:0]       t;
  logic [3:0]       r_step;

  // t = 2r + bit <= 21, so one conditional subtract keeps r in 0..10.
  always_comb begin
    t      = {r_q, 1'b0} + {4'b0000, sr_q[WIDTH-1]};
    r_step = (t >= 5'(MOD)) ? 4'(t - 5'(MOD)) : t[3:0];
  end

  always_comb begin
    sr_d = sr_q;
    r_d  = r_q;
    if (load_i) begin
      sr_d = din_i;
      r_d  = 4'd0;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
      r_d  = r_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
      r_q  <= 4'd0;
    end else begin
      sr_q <= sr_d;
      r_q  <= r_d;
    end
  end

  assign r_next_o = r_step;

endmodule

// File: rtl/rns11_tc_forward_converter.sv
// Bit-serial binary -> mod-11 thermometer-code converter for an operand pair,
// with valid/ready handshakes on both sides.
module rns11_tc_forward_converter
  import rns11_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TC_W-1:0]  out_a_tc,
  output logic [TC_W-1:0]  out_b_tc
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [TC_W-1:0] out_a_q, out_a_d;
  logic [TC_W-1:0] out_b_q, out_b_d;
  logic            accept;
  logic            shift_en;
  logic [3:0]      ra_next, rb_next;

  // Decoded from state only; no combinational path from in_valid.
  assign in_ready = !rst && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign shift_en = (state_q == SHIFT);

  rns11_serial_residue #(.WIDTH(WIDTH)) u_res_a (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .shift_i  (shift_en),
    .din_i    (in_a),
    .r_next_o (ra_next)
  );

  rns11_serial_residue #(.WIDTH(WIDTH)) u_res_b (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .shift_i  (shift_en),
    .din_i    (in_b),
    .r_next_o (rb_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = CW'(WIDTH);
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_a_d     = tc_encode(ra_next);
          out_b_d     = tc_encode(rb_next);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a_tc  = out_a_q;
  assign out_b_tc  = out_b_q;

endmodule

// File: tb/tb_rns11_tc_forward_converter.sv
// Self-checking bench: directed cases plus randomized traffic scored against
// an arithmetic model (operand % 11 -> thermometer code).
module tb_rns11_tc_forward_converter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [9:0]       out_a_tc;
  logic [9:0]       out_b_tc;

  rns11_tc_forward_converter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a_tc  (out_a_tc),
    .out_b_tc  (out_b_tc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: thermometer code of v mod 11 is (2^(v mod 11)) - 1.
  function automatic logic [9:0] tc_ref(input logic [WIDTH-1:0] v);
    int m;
    m = int'(v) % 11;
    return 10'((1 << m) - 1);
  endfunction

  typedef struct {
    logic [9:0] ea;
    logic [9:0] eb;
    int         acc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  logic       ov_prev = 1'b0;
  logic       ordy_prev = 1'b0;
  logic [9:0] a_prev, b_prev;
  logic [9:0] last_a = '0, last_b = '0;
  int         n_out = 0;
  logic       b2b_en = 1'b0;
  logic       have_last = 1'b0;
  int         last_acc = 0;

  // Monitor samples mid-cycle; the driver changes inputs 1ns after posedge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      ov_prev   = 1'b0;
      ordy_prev = 1'b0;
    end else begin
      if (q.size() > 0) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (out_valid && !ov_prev) begin
        if (q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
        else chk("latency", cyc - q[0].acc, WIDTH + 1);
      end
      if (out_valid && ov_prev && !ordy_prev) begin
        chk("hold_a", {22'd0, out_a_tc}, {22'd0, a_prev});
        chk("hold_b", {22'd0, out_b_tc}, {22'd0, b_prev});
      end
      if (!out_valid && ov_prev && !ordy_prev) chk("valid_dropped", 32'd0, 32'd1);
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("res_a", {22'd0, out_a_tc}, {22'd0, e.ea});
        chk("res_b", {22'd0, out_b_tc}, {22'd0, e.eb});
        last_a = out_a_tc;
        last_b = out_b_tc;
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.ea  = tc_ref(in_a);
        e.eb  = tc_ref(in_b);
        e.acc = cyc;
        q.push_back(e);
        if (b2b_en && have_last) chk("b2b_spacing", cyc - last_acc, WIDTH + 2);
        last_acc  = cyc;
        have_last = 1'b1;
      end
      ov_prev   = out_valid;
      ordy_prev = out_ready;
      a_prev    = out_a_tc;
      b_prev    = out_b_tc;
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
    if (!ok) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_a", {22'd0, out_a_tc}, 32'd0);
    chk("rst_out_b", {22'd0, out_b_tc}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed values
    send(16'd23, 16'd65535);
    wait_drain();
    chk("d1_a", {22'd0, last_a}, 32'h001);
    chk("d1_b", {22'd0, last_b}, 32'h0FF);
    send(16'd0, 16'd1000);
    wait_drain();
    chk("d2_a", {22'd0, last_a}, 32'h000);
    chk("d2_b", {22'd0, last_b}, 32'h3FF);
    send(16'd11, 16'd12345);
    wait_drain();
    chk("d3_a", {22'd0, last_a}, 32'h000);
    chk("d3_b", {22'd0, last_b}, 32'h007);

    // Backpressure: hold for 20 cycles, then release
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'd100, 16'd200);
    begin
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      chk("bp_valid_seen", {31'd0, seen}, 32'd1);
    end
    repeat (20) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp_drop_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_after_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_a", {22'd0, last_a}, 32'h001);
    chk("bp_b", {22'd0, last_b}, 32'h003);

    // Back-to-back with in_valid held high; operands wiggle every cycle
    have_last = 1'b0;
    b2b_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 4 * (WIDTH + 2); i++) begin
      in_a = WIDTH'($urandom);
      in_b = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    b2b_en = 1'b0;
    wait_drain();

    // Reset in the middle of a conversion aborts it
    send(16'd5, 16'd6);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_a", {22'd0, out_a_tc}, 32'd0);
    repeat (WIDTH + 5) @(negedge clk);
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    send(16'd21, 16'd22);
    wait_drain();
    chk("post_abort_a", {22'd0, last_a}, 32'h3FF);
    chk("post_abort_b", {22'd0, last_b}, 32'h000);

    // Randomized traffic with random backpressure
    begin
      int target;
      target = n_out + 1500;
      for (int i = 0; i < 60000 && n_out < target; i++) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 7))
          0: in_a = '0;
          1: in_a = '1;
          default: in_a = WIDTH'($urandom);
        endcase
        case ($urandom_range(0, 7))
          0: in_b = '1;
          1: in_b = WIDTH'(11 * $urandom_range(0, 5957));
          default: in_b = WIDTH'($urandom);
        endcase
      end
      chk("random_count", {31'd0, n_out >= target}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("final_queue", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
